// File: rtl/reverb_tap_accumulator_if.sv
// reverb_tap_accumulator_if: bundles the sample-period control, memory word stream and mixed-output signals.
// Ports (all signals, no interface ports):
//   sample_start, dry_in, impulses, gain  - per-period control, driven by master
//   mem_data, mem_valid, mem_is_impulse   - memory word stream, driven by master
//   wet_out, out_valid, busy, seq_err, overrun - results, driven by slave
interface reverb_tap_accumulator_if;
    logic        sample_start;
    logic [15:0] dry_in;
    logic [15:0] impulses;
    logic [15:0] gain;
    logic [15:0] mem_data;
    logic        mem_valid;
    logic        mem_is_impulse;
    logic [15:0] wet_out;
    logic        out_valid;
    logic        busy;
    logic        seq_err;
    logic        overrun;
    modport master (
        output sample_start, dry_in, impulses, gain, mem_data, mem_valid, mem_is_impulse,
        input  wet_out, out_valid, busy, seq_err, overrun
    );
    modport slave (
        input  sample_start, dry_in, impulses, gain, mem_data, mem_valid, mem_is_impulse,
        output wet_out, out_valid, busy, seq_err, overrun
    );
endinterface

// File: rtl/reverb_tap_accumulator.sv
// reverb_tap_accumulator: multiplies delayed samples by impulse coefficients, accumulates, then mixes wet with dry into a saturated 16-bit output.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of reverb_tap_accumulator_if (control in, memory words in, mixed sample/status out)
module reverb_tap_accumulator #(
    parameter int ACC_W    = 32,
    parameter int MAX_TAPS = 511
) (
    input logic clk,
    input logic rst_n,
    reverb_tap_accumulator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_IMP, WAIT_SMP, MIX, OUT} state_t;
    state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sh, acc_sat;
    logic [15:0] cnt_q, cnt_d, taps_q, taps_d, taps_in, dry_q, dry_d, gain_q, gain_d;
    logic [15:0] y_q, y_d, wet_q, wet_d, y;
    logic [7:0]  mult_q, mult_d;
    logic        neg_q, neg_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic        seq_err_q, seq_err_d, overrun_q, overrun_d;
    logic signed [24:0] prod, tap;
    logic signed [ACC_W:0] sum;
    logic signed [15:0] s;
    logic signed [32:0] mp;
    logic signed [17:0] w, mix;
    assign bus.wet_out   = wet_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.overrun   = overrun_q;
    always_comb begin
        taps_in = (bus.impulses > 16'(MAX_TAPS)) ? 16'(MAX_TAPS) : bus.impulses;
        prod    = $signed({{9{bus.mem_data[15]}}, bus.mem_data}) * $signed({17'd0, mult_q});
        tap     = neg_q ? -prod : prod;
        // One extra bit catches overflow so the accumulator clamps instead of wrapping
        sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-24){tap[24]}}, tap};
        acc_sat = (sum[ACC_W] == sum[ACC_W-1]) ? sum[ACC_W-1:0] :
                  (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
        acc_sh  = acc_q >>> 8;
        s       = (&acc_sh[ACC_W-1:15] | ~|acc_sh[ACC_W-1:15]) ? acc_sh[15:0] :
                  (acc_sh[ACC_W-1] ? 16'h8000 : 16'h7FFF);
        mp      = $signed({{17{s[15]}}, s}) * $signed({17'd0, gain_q});
        w       = 18'(mp >>> 15);
        mix     = $signed({{2{dry_q[15]}}, dry_q}) + w;
        y       = (&mix[17:15] | ~|mix[17:15]) ? mix[15:0] : (mix[17] ? 16'h8000 : 16'h7FFF);
    end
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        taps_d      = taps_q;
        dry_d       = dry_q;
        gain_d      = gain_q;
        neg_d       = neg_q;
        mult_d      = mult_q;
        y_d         = y_q;
        wet_d       = wet_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q & ~out_valid_q;
        seq_err_d   = seq_err_q;
        overrun_d   = overrun_q;
        if (bus.sample_start) begin
            // A start while busy abandons the current period and restarts cleanly
            overrun_d = overrun_q | (state_q != IDLE);
            seq_err_d = 1'b0;
            dry_d     = bus.dry_in;
            taps_d    = taps_in;
            gain_d    = bus.gain;
            acc_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = (taps_in == 16'd0) ? MIX : WAIT_IMP;
        end else begin
            case (state_q)
                WAIT_IMP: if (bus.mem_valid) begin
                    if (bus.mem_is_impulse) begin
                        neg_d   = bus.mem_data[8];
                        mult_d  = bus.mem_data[7:0];
                        state_d = WAIT_SMP;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                WAIT_SMP: if (bus.mem_valid) begin
                    if (bus.mem_is_impulse) begin
                        neg_d     = bus.mem_data[8];
                        mult_d    = bus.mem_data[7:0];
                        seq_err_d = 1'b1;
                    end else begin
                        acc_d   = acc_sat;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = (cnt_q + 16'd1 == taps_q) ? MIX : WAIT_IMP;
                    end
                end
                MIX: begin
                    y_d     = y;
                    state_d = OUT;
                end
                OUT: begin
                    wet_d       = y_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            taps_q      <= '0;
            dry_q       <= '0;
            gain_q      <= '0;
            neg_q       <= 1'b0;
            mult_q      <= '0;
            y_q         <= '0;
            wet_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            seq_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            taps_q      <= taps_d;
            dry_q       <= dry_d;
            gain_q      <= gain_d;
            neg_q       <= neg_d;
            mult_q      <= mult_d;
            y_q         <= y_d;
            wet_q       <= wet_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            seq_err_q   <= seq_err_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule

// File: tb/tb_reverb_tap_accumulator.sv
// tb_reverb_tap_accumulator: directed self-checking bench for reverb_tap_accumulator.
module tb_reverb_tap_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int n;
    reverb_tap_accumulator_if bus();
    reverb_tap_accumulator #(.ACC_W(32), .MAX_TAPS(511)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [15:0] dry, input logic [15:0] imp, input logic [15:0] g);
        bus.sample_start = 1'b1;
        bus.dry_in = dry;
        bus.impulses = imp;
        bus.gain = g;
        tick();
        bus.sample_start = 1'b0;
    endtask
    task automatic word(input logic [15:0] d, input logic is_imp);
        bus.mem_valid = 1'b1;
        bus.mem_data = d;
        bus.mem_is_impulse = is_imp;
        tick();
        bus.mem_valid = 1'b0;
    endtask
    task automatic wait_ov(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask
    initial begin
        bus.sample_start = 1'b0;
        bus.dry_in = '0;
        bus.impulses = '0;
        bus.gain = '0;
        bus.mem_data = '0;
        bus.mem_valid = 1'b0;
        bus.mem_is_impulse = 1'b0;
        tick();
        tick();
        chk("rst_wet", bus.wet_out, 16'h0000);
        chk("rst_ov", 16'(bus.out_valid), 16'h0);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_seq", 16'(bus.seq_err), 16'h0);
        chk("rst_ovr", 16'(bus.overrun), 16'h0);
        rst_n = 1'b1;
        tick();
        word(16'h1234, 1'b0);
        chk("idle_word_seq", 16'(bus.seq_err), 16'h0);
        chk("idle_word_busy", 16'(bus.busy), 16'h0);
        start(16'h1234, 16'd0, 16'h8000);
        chk("z_busy_rise", 16'(bus.busy), 16'h1);
        chk("z_ov_t1", 16'(bus.out_valid), 16'h0);
        tick();
        chk("z_ov_t2", 16'(bus.out_valid), 16'h0);
        tick();
        chk("z_ov_t3", 16'(bus.out_valid), 16'h1);
        chk("z_wet", bus.wet_out, 16'h1234);
        chk("z_busy_during_ov", 16'(bus.busy), 16'h1);
        tick();
        chk("z_ov_drop", 16'(bus.out_valid), 16'h0);
        chk("z_busy_fall", 16'(bus.busy), 16'h0);
        chk("z_wet_hold", bus.wet_out, 16'h1234);
        start(16'h0000, 16'd1, 16'h7FFF);
        word(16'h0080, 1'b1);
        word(16'h4000, 1'b0);
        wait_ov(n);
        chk("t1_lat", 16'(n), 16'd2);
        chk("t1_wet", bus.wet_out, 16'h1FFF);
        start(16'h8000, 16'd1, 16'h7FFF);
        word(16'h01FF, 1'b1);
        word(16'h7FFF, 1'b0);
        wait_ov(n);
        chk("neg_lat", 16'(n), 16'd2);
        chk("neg_wet", bus.wet_out, 16'h8000);
        start(16'h7000, 16'd3, 16'h7FFF);
        for (int i = 0; i < 3; i++) begin
            word(16'h00FF, 1'b1);
            word(16'h7FFF, 1'b0);
        end
        wait_ov(n);
        chk("three_lat", 16'(n), 16'd2);
        chk("three_wet", bus.wet_out, 16'h7FFF);
        chk("three_seq", 16'(bus.seq_err), 16'h0);
        start(16'h0100, 16'd2, 16'h8000);
        word(16'h0010, 1'b1);
        word(16'h1000, 1'b0);
        word(16'h0040, 1'b1);
        word(16'h0120, 1'b1);
        chk("repl_seq", 16'(bus.seq_err), 16'h1);
        word(16'h0400, 1'b0);
        wait_ov(n);
        chk("repl_lat", 16'(n), 16'd2);
        chk("repl_wet", bus.wet_out, 16'h0180);
        chk("repl_seq_sticky", 16'(bus.seq_err), 16'h1);
        start(16'h0000, 16'd2, 16'h7FFF);
        chk("ovr_seq_clr0", 16'(bus.seq_err), 16'h0);
        word(16'h0080, 1'b1);
        word(16'h4000, 1'b0);
        word(16'h1000, 1'b0);
        chk("ovr_seq_set", 16'(bus.seq_err), 16'h1);
        chk("ovr_pre", 16'(bus.overrun), 16'h0);
        start(16'h0000, 16'd1, 16'h7FFF);
        chk("ovr_set", 16'(bus.overrun), 16'h1);
        chk("ovr_seq_clr", 16'(bus.seq_err), 16'h0);
        chk("ovr_no_ov", 16'(bus.out_valid), 16'h0);
        chk("ovr_wet_keep", bus.wet_out, 16'h0180);
        chk("ovr_busy", 16'(bus.busy), 16'h1);
        word(16'h0080, 1'b1);
        word(16'h4000, 1'b0);
        wait_ov(n);
        chk("ovr_restart_lat", 16'(n), 16'd2);
        chk("ovr_restart_wet", bus.wet_out, 16'h1FFF);
        chk("ovr_sticky", 16'(bus.overrun), 16'h1);
        start(16'h0000, 16'd1, 16'h7FFF);
        word(16'h0080, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mrst_wet", bus.wet_out, 16'h0000);
        chk("mrst_ov", 16'(bus.out_valid), 16'h0);
        chk("mrst_busy", 16'(bus.busy), 16'h0);
        chk("mrst_seq", 16'(bus.seq_err), 16'h0);
        chk("mrst_ovr", 16'(bus.overrun), 16'h0);
        rst_n = 1'b1;
        tick();
        word(16'h4000, 1'b0);
        chk("mrst_idle_busy", 16'(bus.busy), 16'h0);
        start(16'h1234, 16'd0, 16'h8000);
        wait_ov(n);
        chk("post_lat", 16'(n), 16'd2);
        chk("post_wet", bus.wet_out, 16'h1234);
        chk("post_ovr", 16'(bus.overrun), 16'h0);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reverb_tap_accumulator.md
# reverb_tap_accumulator

Downstream stage of the memory controller in the pedal datapath. Once per ADC sample period it takes the stream of alternating impulse words and delayed-sample words read back from memory. It multiplies each delayed sample by its impulse coefficient and accumulates the signed sum. It then mixes the scaled wet sum with the dry input and presents one saturated 16-bit output sample to the DAC path.

## Interface
Parameters:
- ACC_W, 32, accumulator width in bits (signed)
- MAX_TAPS, 511, largest accepted `impulses` value; larger values clamp to this

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sample_start  input  1  one-clk pulse at the start of each ADC sample period
- dry_in  input  16  signed dry sample; latched on `sample_start`
- mem_data  input  16  word read from memory
- mem_valid  input  1  `mem_data` is valid this clk (one-clk pulse per word)
- mem_is_impulse  input  1  1 means `mem_data` is an impulse word; 0 means it is a delayed sample
- impulses  input  16  tap count for this period; latched on `sample_start`
- gain  input  16  unsigned Q1.15 wet gain; latched on `sample_start`
- wet_out  output  16  signed mixed output sample
- out_valid  output  1  one-clk pulse when `wet_out` updates
- busy  output  1  high from `sample_start` until `out_valid`
- seq_err  output  1  sticky protocol error; cleared on `sample_start`
- overrun  output  1  sticky; set when `sample_start` arrives while busy; cleared only by reset

## Operation
Impulse word format:
- [15:13] top_offset and [12:9] bottom_offset: ignored here; they are consumed by the address side
- [8] negative
- [7:0] multiplier, unsigned Q0.8

States:
- IDLE: waiting for `sample_start`.
- On `sample_start`:
  - latch `dry_in`, `impulses` (clamped to MAX_TAPS) and `gain`
  - clear the accumulator and tap counter
  - go to WAIT_IMP, or to MIX if `impulses`==0
- WAIT_IMP: accept only words with `mem_valid && mem_is_impulse`.
  - Latch `negative` and `multiplier`, then go to WAIT_SMP.
  - A sample word arriving here is dropped and sets `seq_err`.
- WAIT_SMP: accept only words with `mem_valid && !mem_is_impulse`.
  - Product = signed(`mem_data`) × {0, multiplier}, 25-bit signed.
  - The product is negated if `negative`=1, then sign-extended to ACC_W and added to the accumulator.
  - The tap counter increments. When it reaches the latched tap count, go to MIX; otherwise go to WAIT_IMP.
  - An impulse word arriving here replaces the latched coefficient and sets `seq_err`.
- MIX: one clk.
  - S = saturate16(acc >>> 8), arithmetic shift.
  - W = (S × gain) >>> 15.
  - Y = saturate16(dry + W), using 18-bit intermediates.
  - Y is registered into the output stage. Go to OUT.
- OUT: one clk.
  - `wet_out` ← Y and `out_valid`=1.
  - Go to IDLE.

Saturation limits are 16'h7FFF and 16'h8000, for both the tap sum and the final mix.

The accumulator never wraps. Internal saturation at ACC_W limits is required.

`sample_start` while busy (any state except IDLE):
- set `overrun`
- discard the partial accumulation
- leave `wet_out` unchanged with no `out_valid`
- restart as a fresh `sample_start` in the same clk

`mem_valid` in IDLE, MIX or OUT is ignored and does not set `seq_err`.

## Timing
- Reset values: `wet_out`=0, `out_valid`=0, `busy`=0, `seq_err`=0, `overrun`=0, state IDLE, accumulator 0.
- Latency from `sample_start` with `impulses`=0: MIX on the next clk, so `out_valid` is 2 clks after the `sample_start` edge.
- Latency from the last sample word accepted at edge N: MIX at N+1, `out_valid` high during the clk after N+2 edge, i.e. 2 clks.
- Throughput: one word per clk, so a full tap pair needs a minimum of 2 clks.
- `busy` rises on the clk after `sample_start` and falls together with the `out_valid` pulse ending.
- `wet_out` holds its value between `out_valid` pulses.

## Test plan
- Reset mid-WAIT_SMP (`rst_n` low for 1 clk) -> all outputs 0, state IDLE, next period starts cleanly.
- `impulses`=0, `dry_in`=16'h1234, `gain`=16'h8000 -> `wet_out`=16'h1234, `out_valid` 2 clks after `sample_start`.
- One tap: impulse 16'h0080 (multiplier 0.5), sample 16'h4000, `dry_in`=0, `gain`=16'h7FFF -> S=16'h2000, `wet_out`=16'h1FFF.
- Negative tap: impulse 16'h01FF, sample 16'h7FFF, `dry_in`=16'h8000, `gain`=16'h7FFF -> negative sum saturates, `wet_out`=16'h8000.
- Three taps each 16'h00FF × 16'h7FFF, `dry_in`=16'h7000, `gain`=16'h7FFF -> S clamps to 16'h7FFF, `wet_out`=16'h7FFF.
- Two sample words in a row after an impulse, then `sample_start` during WAIT_IMP -> `seq_err`=1, then cleared; `overrun`=1; no `out_valid`; prior `wet_out` retained.
